// File: rtl/fsmc_pkg.sv
// fsmc_bank_bridge shared definitions.
// Register map, CTRL bit layout and ID word.
package fsmc_pkg;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_INDEX = 2'd2;
    localparam logic [1:0] REG_DB    = 2'd3;

    localparam int CTRL_AUTO     = 0;
    localparam int CTRL_CHAN_LSB = 1;

    localparam logic [15:0] ID_CONST = 16'hF5C2;

endpackage

// File: rtl/fsmc_strobe_sync.sv
// Multi-stage synchroniser for an FSMC strobe pin.
// Edges are suppressed until a settled idle-high level is seen.
module fsmc_strobe_sync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic reset_l,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC-1:0] sync_q;
    logic [SYNC-1:0] fill_q;
    logic            prev_q;
    logic            armed_q;

    // Shift the pin in; fill_q marks when the chain holds real samples.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync_q  <= '1;
            fill_q  <= '0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC-2:0], pin_i};
            fill_q  <= {fill_q[SYNC-2:0], 1'b1};
            prev_q  <= sync_q[SYNC-1];
            armed_q <= armed_q | (fill_q[SYNC-1] & sync_q[SYNC-1]);
        end
    end

    assign level_o = sync_q[SYNC-1];
    assign rise_o  = armed_q & sync_q[SYNC-1] & ~prev_q;
    assign fall_o  = armed_q & ~sync_q[SYNC-1] & prev_q;

endmodule

// File: rtl/fsmc_bank_bridge.sv
// FSMC slave bridge: host register window onto NCHAN RAM banks,
// plus an independent synchronous fabric read port.
module fsmc_bank_bridge
    import fsmc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 512,
    parameter int NCHAN = 2,
    parameter int SYNC  = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          nce,
    input  logic          noe,
    input  logic          nwe,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_oe,
    input  logic [CW-1:0] fab_chan,
    input  logic [AW-1:0] fab_addr,
    output logic [DW-1:0] fab_rdata,
    output logic          doorbell,
    output logic [DW-1:0] doorbell_data
);

    localparam logic [CW-1:0] CMAX = CW'(NCHAN - 1);
    localparam logic [AW-1:0] AMAX = '1;

    logic [DW-1:0] mem [NCHAN*DEPTH];

    logic          noe_lvl, noe_fall, noe_rise_unused;
    logic          nwe_rise, nwe_lvl_unused, nwe_fall_unused;
    logic          wr_stb, rd_stb;

    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] chan_q, chan_d;
    logic          auto_q, auto_d;
    logic          wrap_q, wrap_d;
    logic          db_q, db_d;
    logic [DW-1:0] db_data_q, db_data_d;
    logic [DW-1:0] latch_q;
    logic [DW-1:0] fab_q;

    logic          mem_we;
    logic          step;
    logic [CW-1:0] chan_raw, chan_wr, fchan;
    logic [DW-1:0] ctrl_rd;

    fsmc_strobe_sync #(.SYNC(SYNC)) u_noe (
        .clk     (clk),
        .reset_l (reset_l),
        .pin_i   (noe),
        .level_o (noe_lvl),
        .rise_o  (noe_rise_unused),
        .fall_o  (noe_fall)
    );

    fsmc_strobe_sync #(.SYNC(SYNC)) u_nwe (
        .clk     (clk),
        .reset_l (reset_l),
        .pin_i   (nwe),
        .level_o (nwe_lvl_unused),
        .rise_o  (nwe_rise),
        .fall_o  (nwe_fall_unused)
    );

    // A write wins over a coincident read.
    assign wr_stb = nwe_rise & ~nce;
    assign rd_stb = noe_fall & ~nce & ~wr_stb;

    assign chan_raw = data_in[CTRL_CHAN_LSB +: CW];
    assign chan_wr  = (chan_raw > CMAX) ? CMAX : chan_raw;
    assign fchan    = (fab_chan > CMAX) ? CMAX : fab_chan;

    // Assemble the CTRL readback word.
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_AUTO] = auto_q;
        ctrl_rd[CTRL_CHAN_LSB +: CW] = chan_q;
        ctrl_rd[DW-1] = wrap_q;
    end

    // Register-window next state from the decoded strobe.
    always_comb begin
        idx_d     = idx_q;
        chan_d    = chan_q;
        auto_d    = auto_q;
        wrap_d    = wrap_q;
        db_d      = 1'b0;
        db_data_d = db_data_q;
        mem_we    = 1'b0;
        step      = 1'b0;
        if (wr_stb) begin
            unique case (addr)
                REG_DATA: begin
                    mem_we = 1'b1;
                    step   = auto_q;
                end
                REG_CTRL: begin
                    auto_d = data_in[CTRL_AUTO];
                    chan_d = chan_wr;
                end
                REG_INDEX: begin
                    idx_d  = data_in[AW-1:0];
                    wrap_d = 1'b0;
                end
                REG_DB: begin
                    db_d      = 1'b1;
                    db_data_d = data_in;
                end
            endcase
        end else if (rd_stb && addr == REG_DATA) begin
            step = auto_q;
        end
        if (step) begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AMAX) wrap_d = 1'b1;
        end
    end

    // Register-window state.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            idx_q     <= '0;
            chan_q    <= '0;
            auto_q    <= 1'b1;
            wrap_q    <= 1'b0;
            db_q      <= 1'b0;
            db_data_q <= '0;
        end else begin
            idx_q     <= idx_d;
            chan_q    <= chan_d;
            auto_q    <= auto_d;
            wrap_q    <= wrap_d;
            db_q      <= db_d;
            db_data_q <= db_data_d;
        end
    end

    // Host RAM write port.
    always_ff @(posedge clk) begin
        if (mem_we) mem[{chan_q, idx_q}] <= data_in;
    end

    // Host read latch, loaded only on an accepted read strobe.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            latch_q <= '0;
        end else if (rd_stb) begin
            unique case (addr)
                REG_DATA:  latch_q <= mem[{chan_q, idx_q}];
                REG_CTRL:  latch_q <= ctrl_rd;
                REG_INDEX: latch_q <= DW'(idx_q);
                REG_DB:    latch_q <= DW'(ID_CONST);
            endcase
        end
    end

    // Fabric read port; read-before-write on address collision.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) fab_q <= '0;
        else          fab_q <= mem[{fchan, fab_addr}];
    end

    assign data_out      = latch_q;
    assign data_oe       = ~nce & ~noe_lvl;
    assign fab_rdata     = fab_q;
    assign doorbell      = db_q;
    assign doorbell_data = db_data_q;

endmodule

// File: tb/tb_fsmc_bank_bridge.sv
// Directed bench for fsmc_bank_bridge.
// Host reads are checked against a queue of expected words.
module tb_fsmc_bank_bridge;
    import fsmc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        nce = 1'b1;
    logic        noe = 1'b1;
    logic        nwe = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_oe;
    logic [0:0]  fab_chan = '0;
    logic [8:0]  fab_addr = '0;
    logic [15:0] fab_rdata;
    logic        doorbell;
    logic [15:0] doorbell_data;

    int n_assert = 0;
    int n_fail = 0;
    int db_cnt = 0;
    logic [31:0] exp_q[$];

    fsmc_bank_bridge dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .nce           (nce),
        .noe           (noe),
        .nwe           (nwe),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .fab_chan      (fab_chan),
        .fab_addr      (fab_addr),
        .fab_rdata     (fab_rdata),
        .doorbell      (doorbell),
        .doorbell_data (doorbell_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (doorbell === 1'b1) db_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hwrite(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        nce = 0; addr = a; data_in = d; nwe = 0;
        repeat (4) @(posedge clk); #1;
        nwe = 1;
        repeat (5) @(posedge clk); #1;
        nce = 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic hread(input logic [1:0] a, input string tag);
        logic [31:0] e;
        @(posedge clk); #1;
        nce = 0; addr = a; noe = 0;
        repeat (6) @(posedge clk); #1;
        if (exp_q.size() == 0) begin
            e = 32'hDEAD_0000;
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed empty queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(data_out), e);
        end
        chk({tag, "_oe1"}, 32'(data_oe), 1);
        noe = 1;
        repeat (4) @(posedge clk); #1;
        chk({tag, "_oe0"}, 32'(data_oe), 0);
        nce = 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic fread(input logic c, input logic [8:0] a,
                         input logic [15:0] e, input string tag);
        @(posedge clk); #1;
        fab_chan = c; fab_addr = a;
        @(posedge clk); #1;
        chk(tag, 32'(fab_rdata), 32'(e));
    endtask

    initial begin
        int db0;
        logic [15:0] pre [4];
        pre[0] = 16'h1111; pre[1] = 16'h2222;
        pre[2] = 16'h3333; pre[3] = 16'h4444;

        repeat (3) @(posedge clk); #1;
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_oe", 32'(data_oe), 0);
        chk("rst_db", 32'(doorbell), 0);
        chk("rst_dbdata", 32'(doorbell_data), 0);
        chk("rst_fab", 32'(fab_rdata), 0);
        reset_l = 1;
        repeat (5) @(posedge clk);

        hwrite(REG_INDEX, 16'h01FE);
        hwrite(REG_DATA, 16'hAAAA);
        hwrite(REG_DATA, 16'hBBBB);
        hwrite(REG_DATA, 16'hCCCC);
        exp_q.push_back(32'h0001);
        hread(REG_INDEX, "wrap_index");
        exp_q.push_back(32'h8001);
        hread(REG_CTRL, "wrap_ctrl");
        fread(0, 9'h1FE, 16'hAAAA, "fab_1fe");
        fread(0, 9'h1FF, 16'hBBBB, "fab_1ff");
        fread(0, 9'h000, 16'hCCCC, "fab_000");

        hwrite(REG_CTRL, 16'h0002);
        hwrite(REG_INDEX, 16'h0005);
        hwrite(REG_DATA, 16'h1234);
        hwrite(REG_DATA, 16'h5678);
        exp_q.push_back(32'h0005);
        hread(REG_INDEX, "noauto_index");
        exp_q.push_back(32'h0002);
        hread(REG_CTRL, "chan1_ctrl");
        fread(1, 9'h005, 16'h5678, "fab_c1_5");
        fread(0, 9'h1FE, 16'hAAAA, "bank0_keep_a");
        fread(0, 9'h000, 16'hCCCC, "bank0_keep_b");

        hwrite(REG_CTRL, 16'h0003);
        hwrite(REG_INDEX, 16'h0000);
        for (int i = 0; i < 4; i++) hwrite(REG_DATA, pre[i]);
        hwrite(REG_INDEX, 16'h0000);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(pre[i]));
        for (int i = 0; i < 4; i++) hread(REG_DATA, $sformatf("burst%0d", i));
        exp_q.push_back(32'h0004);
        hread(REG_INDEX, "burst_index");

        db0 = db_cnt;
        hwrite(REG_DB, 16'hBEEF);
        chk("db_pulse", 32'(db_cnt - db0), 1);
        chk("db_data", 32'(doorbell_data), 32'hBEEF);
        exp_q.push_back(32'hF5C2);
        hread(REG_DB, "id_read");

        hwrite(REG_CTRL, 16'h0002);
        hwrite(REG_INDEX, 16'h0005);
        @(posedge clk); #1;
        fab_chan = 1; fab_addr = 9'h005;
        nce = 0; addr = REG_DATA; data_in = 16'h9ABC; nwe = 0;
        repeat (4) @(posedge clk); #1;
        nwe = 1;
        repeat (3) @(posedge clk); #1;
        chk("coll_old", 32'(fab_rdata), 32'h5678);
        repeat (2) @(posedge clk); #1;
        chk("coll_new", 32'(fab_rdata), 32'h9ABC);
        nce = 1;
        repeat (2) @(posedge clk);

        hwrite(REG_CTRL, 16'h0003);
        hwrite(REG_INDEX, 16'h0002);
        @(posedge clk); #1;
        nce = 0; addr = REG_DATA; noe = 0;
        repeat (6) @(posedge clk); #1;
        chk("held_read", 32'(data_out), 32'h3333);
        reset_l = 0;
        #1;
        chk("mid_rst_oe", 32'(data_oe), 0);
        chk("mid_rst_dout", 32'(data_out), 0);
        chk("mid_rst_dbdata", 32'(doorbell_data), 0);
        repeat (3) @(posedge clk); #1;
        reset_l = 1;
        repeat (10) @(posedge clk); #1;
        noe = 1;
        repeat (4) @(posedge clk); #1;
        nce = 1;
        repeat (2) @(posedge clk);
        exp_q.push_back(32'h0000);
        hread(REG_INDEX, "post_rst_index");
        exp_q.push_back(32'h0001);
        hread(REG_CTRL, "post_rst_ctrl");
        exp_q.push_back(32'hCCCC);
        hread(REG_DATA, "post_rst_ram");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fsmc_bank_bridge.md
# fsmc_bank_bridge

Parametrised STM32 FSMC slave bridge: a host on the external memory bus reads and writes NCHAN banks of DEPTH×DW on-chip RAM through a four-register window with auto-incrementing index, wrap detection and a doorbell. FPGA fabric logic reads the same banks through an independent synchronous port. Sits between the top-level FSMC pins (tri-state handled at top) and fabric consumers. Successor to the fixed single-bank 512×16 FSMC buffer.

## Interface
Parameters:
- DW, 16, data bus and RAM word width (8..32)
- DEPTH, 512, words per bank, power of two
- NCHAN, 2, number of RAM banks (1..8)
- SYNC, 2, synchroniser stages on noe/nwe (≥2)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock (PLL output)
- reset_l  in  1  asynchronous active-low reset
- nce  in  1  FSMC chip select, active low
- noe  in  1  FSMC output enable, active low
- nwe  in  1  FSMC write enable, active low
- addr  in  2  register select
- data_in  in  DW  bus data from pads
- data_out  out  DW  read data to pads
- data_oe  out  1  pad output enable
- fab_chan  in  clog2(NCHAN)  fabric read bank
- fab_addr  in  clog2(DEPTH)  fabric read word
- fab_rdata  out  DW  fabric read data
- doorbell  out  1  one-cycle pulse on host DOORBELL write
- doorbell_data  out  DW  value of last DOORBELL write

## Operation
- noe, nwe each pass a SYNC-stage synchroniser; read strobe = synchronised noe falling edge AND nce low; write strobe = synchronised nwe rising edge AND nce low. nce sampled unsynchronised (stable across strobe).
- Register map: 0 DATA, 1 CTRL, 2 INDEX, 3 DOORBELL/ID.
- DATA write: mem[chan][index] <= data_in; if CTRL.auto, index++.
- DATA read: latch <= mem[chan][index]; if CTRL.auto, index++.
- CTRL write: bit0 auto, bits[clog2(NCHAN):1] chan (out-of-range chan values clamp to NCHAN-1). CTRL read: {wrap at bit DW-1, chan, auto}.
- INDEX write: index <= data_in[clog2(DEPTH)-1:0], clears wrap. INDEX read returns zero-extended index.
- DOORBELL write: doorbell_data <= data_in, doorbell pulses 1 cycle. Read returns ID constant 16'hF5C2 (zero-extended/truncated to DW).
- Index increment from DEPTH-1 wraps to 0 and sets sticky wrap.
- Write and read strobe in same cycle: write performed, read ignored, latch unchanged.
- data_oe = nce low AND synchronised noe low; data_out = latch.
- Fabric port: fab_rdata <= mem[fab_chan][fab_addr] every cycle; same-address host write in same cycle returns old data.

## Timing
- Reset values: index 0, chan 0, auto 1, wrap 0, latch 0, data_out 0, data_oe 0, doorbell 0, doorbell_data 0, fab_rdata 0; synchroniser flops reset to 1 (idle, no false edge). RAM contents not cleared.
- Reset mid-transaction aborts it; first strobe needs a fresh edge after reset_l rises.
- Strobe detected SYNC+1 cycles after pin edge; latch valid one cycle after read strobe; host read setup ≥ SYNC+3 clk periods.
- Register updates visible one cycle after strobe; fabric read latency 1 cycle.

## Structure
- Package fsmc_pkg: register address constants, CTRL bit positions, ID constant.
- Sub-module fsmc_strobe_sync: SYNC-stage synchroniser with rise/fall edge outputs, instantiated for noe and nwe.
- RAM as NCHAN×DEPTH inferred dual-port block (host write/read port, fabric read port).

## Test plan
- Reset, write INDEX=0x1FE, DATA 0xAAAA, 0xBBBB, 0xCCCC -> mem[0][0x1FE..0x1FF,0x000] hold values, INDEX reads 0x001, CTRL bit15=1.
- CTRL chan=1, auto=0; two DATA writes 0x1234, 0x5678 at INDEX 5 -> mem[1][5]=0x5678, index stays 5, bank 0 unchanged.
- Preload mem[1][0..3], INDEX=0, four DATA reads -> bus returns values in order, data_oe only while nce and noe low.
- DOORBELL write 0xBEEF -> doorbell one-cycle pulse, doorbell_data=0xBEEF; DOORBELL read -> 0xF5C2.
- Fabric reads fab_chan=1, fab_addr=5 during host write to same word -> old value, new value next cycle.
- Assert reset_l during held-low noe -> data_oe 0 immediately, no index change after release until next noe edge.
